// File: rtl/count_monitor.sv
// count_monitor: integrity checker for a 3-bit free-running up counter.
// Samples count_in every clock, expects +1 mod 8 per step, locks after
// LOCK_N consecutive good steps, reports wraps while locked and counts
// and latches step faults until clr_err.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no valid previous sample yet; next edge only captures
// ACQUIRE | counting consecutive good steps towards lock; bad steps silent
// LOCKED  | tracking; 7->0 steps reported as wraps, bad step -> FAULT
// FAULT   | sticky; bad steps still counted, left only via clr_err
module count_monitor #(
  parameter int LOCK_N = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        count_in,
  input  logic              clr_err,
  output logic              locked,
  output logic              fault,
  output logic              wrap_pulse,
  output logic              err_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  // run counts 0..LOCK_N-1; the step that would reach LOCK_N locks instead
  localparam logic [3:0] RUN_LAST = 4'(LOCK_N - 1);

  state_t     state;
  logic [2:0] prev;
  logic [3:0] run;

  logic [2:0] expect_next;
  logic       good;
  logic       checking;
  logic       bad_seen;
  logic       err_full;

  // Step classification against the previous sample (3-bit wrap makes 7->0 good)
  always_comb begin
    expect_next = prev + 3'd1;
    good        = (count_in == expect_next);
    checking    = (state == LOCKED) || (state == FAULT);
    bad_seen    = checking && !good;
    err_full    = &err_cnt;
  end

  // Main sequencer: state, lock run, registered status and wrap reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= 3'd0;
      run        <= 4'd0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      prev       <= count_in;
      wrap_pulse <= 1'b0;
      case (state)
        IDLE: begin
          state <= ACQUIRE;
          run   <= 4'd0;
        end
        ACQUIRE: begin
          if (good) begin
            if (run == RUN_LAST) begin
              state  <= LOCKED;
              locked <= 1'b1;
              run    <= 4'd0;
            end else begin
              run <= run + 4'd1;
            end
          end else begin
            run <= 4'd0;
          end
        end
        LOCKED: begin
          if (good) begin
            if (count_in == 3'd0) begin
              wrap_pulse <= 1'b1;
              wrap_cnt   <= wrap_cnt + WRAP_W'(1);
            end
          end else begin
            // a clear arriving with the fault skips the FAULT latch entirely
            locked <= 1'b0;
            run    <= 4'd0;
            if (clr_err) begin
              state <= ACQUIRE;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end
        end
        FAULT: begin
          if (clr_err) begin
            state <= ACQUIRE;
            fault <= 1'b0;
            run   <= 4'd0;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
          fault  <= 1'b0;
          run    <= 4'd0;
        end
      endcase
    end
  end

  // Error pulse and saturating error count; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= bad_seen;
      if (clr_err) begin
        err_cnt <= '0;
      end else if (bad_seen && !err_full) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Testbench for count_monitor: two instances (default widths and 2-bit
// counters) driven by the same stimulus and compared against a reference
// model built from the step rules with plain integer arithmetic.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count_in;
  logic       clr_err;

  logic       locked, fault, wrap_pulse, err_pulse;
  logic [7:0] wrap_cnt, err_cnt;
  logic       locked_s, fault_s, wrap_pulse_s, err_pulse_s;
  logic [1:0] wrap_cnt_s, err_cnt_s;

  count_monitor #(.LOCK_N(4), .WRAP_W(8), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .clr_err(clr_err),
    .locked(locked), .fault(fault), .wrap_pulse(wrap_pulse),
    .err_pulse(err_pulse), .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
  );

  count_monitor #(.LOCK_N(4), .WRAP_W(2), .ERR_W(2)) dut_s (
    .clk(clk), .rst(rst), .count_in(count_in), .clr_err(clr_err),
    .locked(locked_s), .fault(fault_s), .wrap_pulse(wrap_pulse_s),
    .err_pulse(err_pulse_s), .wrap_cnt(wrap_cnt_s), .err_cnt(err_cnt_s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0 unprimed, 1 hunting, 2 locked, 3 faulted
  int mode, streak, last, wraps, errs, up, edge_n;
  bit m_wp, m_ep;

  logic [19:0] obs_main;
  logic [7:0]  obs_small;
  assign obs_main  = {locked, fault, wrap_pulse, err_pulse, wrap_cnt, err_cnt};
  assign obs_small = {locked_s, fault_s, wrap_pulse_s, err_pulse_s, wrap_cnt_s, err_cnt_s};

  function automatic void model_reset();
    mode = 0; streak = 0; last = 0; wraps = 0; errs = 0; m_wp = 0; m_ep = 0;
  endfunction

  function automatic void model_step(int ci, bit clr);
    bit ok;
    ok = (ci == (last + 1) % 8);
    m_wp = 0;
    m_ep = 0;
    if (mode == 0) begin
      mode = 1; streak = 0;
    end else if (mode == 1) begin
      streak = ok ? streak + 1 : 0;
      if (streak == 4) begin mode = 2; streak = 0; end
    end else if (mode == 2) begin
      if (ok && ci == 0) begin m_wp = 1; wraps++; end
      if (!ok) begin m_ep = 1; errs++; mode = clr ? 1 : 3; streak = 0; end
    end else begin
      if (!ok) begin m_ep = 1; errs++; end
      if (clr) begin mode = 1; streak = 0; end
    end
    if (clr) errs = 0;
    last = ci;
  endfunction

  function automatic logic [19:0] exp_main();
    int e;
    e = (errs > 255) ? 255 : errs;
    return {mode == 2, mode == 3, m_wp, m_ep, 8'(wraps % 256), 8'(e)};
  endfunction

  function automatic logic [7:0] exp_small();
    int e;
    e = (errs > 3) ? 3 : errs;
    return {mode == 2, mode == 3, m_wp, m_ep, 2'(wraps % 4), 2'(e)};
  endfunction

  task automatic tick(input int ci, input bit clr);
    @(negedge clk);
    count_in = ci[2:0];
    clr_err  = clr;
    @(posedge clk);
    model_step(ci, clr);
    edge_n++;
    #1;
  endtask

  task automatic clean(input bit clr);
    tick(up % 8, clr);
    up++;
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    up = 0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; count_in = 3'd0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs_main !== 20'h0) begin bad++; $display("FAIL reset_main got=%h want=0", obs_main); end
    total++;
    if (obs_small !== 8'h0) begin bad++; $display("FAIL reset_small got=%h want=0", obs_small); end
    @(negedge clk);
    rst = 1'b0;
    up = 0;
    edge_n = 0;
  endtask

  task automatic test_lock_wrap();
    for (int i = 1; i <= 17; i++) begin
      clean(1'b0);
      total++;
      if (obs_main !== exp_main()) begin bad++; $display("FAIL lock_wrap_main edge=%0d got=%h want=%h", i, obs_main, exp_main()); end
      total++;
      if (obs_small !== exp_small()) begin bad++; $display("FAIL lock_wrap_small edge=%0d got=%h want=%h", i, obs_small, exp_small()); end
      if (i == 4) begin
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL lock_edge4 got=%b want=0", locked); end
      end
      if (i == 5) begin
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL lock_edge5 got=%b want=1", locked); end
      end
      if (i == 9) begin
        total++;
        if ({wrap_pulse, wrap_cnt} !== {1'b1, 8'd1}) begin bad++; $display("FAIL first_wrap got=%b/%0d want=1/1", wrap_pulse, wrap_cnt); end
      end
      if (i == 10) begin
        total++;
        if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL wrap_width got=%b want=0", wrap_pulse); end
      end
      if (i == 17) begin
        total++;
        if (wrap_cnt !== 8'd2) begin bad++; $display("FAIL second_wrap got=%0d want=2", wrap_cnt); end
      end
    end
  endtask

  task automatic test_upset();
    int guard = 0;
    while (up % 8 != 3 && guard < 16) begin clean(1'b0); guard++; end
    tick(5, 1'b0);
    up = 6;
    total++;
    if ({err_pulse, err_cnt, fault, locked} !== {1'b1, 8'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL upset got ep=%b err=%0d f=%b l=%b want 1/1/1/0", err_pulse, err_cnt, fault, locked);
    end
    for (int i = 0; i < 20; i++) begin
      clean(1'b0);
      total++;
      if (obs_main !== exp_main() || fault !== 1'b1 || wrap_pulse !== 1'b0) begin
        bad++; $display("FAIL fault_sticky cyc=%0d got=%h want=%h", i, obs_main, exp_main());
      end
    end
    clean(1'b1);
    total++;
    if ({err_cnt, fault, locked} !== {8'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL clr_fault got err=%0d f=%b l=%b want 0/0/0", err_cnt, fault, locked);
    end
    for (int j = 1; j <= 4; j++) begin
      clean(1'b0);
      total++;
      if (locked !== (j == 4) || obs_small !== exp_small()) begin
        bad++; $display("FAIL relock step=%0d got l=%b s=%h want l=%b s=%h", j, locked, obs_small, (j == 4), exp_small());
      end
    end
  endtask

  task automatic test_glitch();
    int seq [9] = '{0, 1, 2, 6, 7, 0, 1, 2, 3};
    restart();
    for (int k = 0; k < 9; k++) begin
      tick(seq[k], 1'b0);
      total++;
      if (err_pulse !== 1'b0 || err_cnt !== 8'd0 || locked !== (k >= 7)) begin
        bad++; $display("FAIL glitch idx=%0d got ep=%b err=%0d l=%b want 0/0/%b", k, err_pulse, err_cnt, locked, (k >= 7));
      end
      total++;
      if (obs_main !== exp_main()) begin bad++; $display("FAIL glitch_model idx=%0d got=%h want=%h", k, obs_main, exp_main()); end
    end
    up = 4;
  endtask

  task automatic test_saturation();
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(3, 1'b0);
      pulses += int'(err_pulse_s);
      total++;
      if (obs_small !== exp_small()) begin bad++; $display("FAIL sat_step i=%0d got=%h want=%h", i, obs_small, exp_small()); end
    end
    total++;
    if (pulses != 5 || err_cnt_s !== 2'd3 || err_cnt !== 8'd5) begin
      bad++; $display("FAIL saturation got pulses=%0d err_s=%0d err=%0d want 5/3/5", pulses, err_cnt_s, err_cnt);
    end
  endtask

  task automatic test_rollover();
    restart();
    for (int i = 1; i <= 44; i++) begin
      clean(1'b0);
      total++;
      if (obs_small !== exp_small()) begin bad++; $display("FAIL roll_step edge=%0d got=%h want=%h", i, obs_small, exp_small()); end
    end
    total++;
    if (wrap_cnt_s !== 2'd1 || wrap_cnt !== 8'd5 || locked !== 1'b1) begin
      bad++; $display("FAIL rollover got ws=%0d w=%0d l=%b want 1/5/1", wrap_cnt_s, wrap_cnt, locked);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (obs_main !== 20'h0 || obs_small !== 8'h0) begin
      bad++; $display("FAIL async_reset got=%h/%h want=0/0", obs_main, obs_small);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    up = 0;
    for (int i = 1; i <= 6; i++) begin
      clean(1'b0);
      total++;
      if (locked !== (i >= 5) || obs_main !== exp_main()) begin
        bad++; $display("FAIL relock_after_rst edge=%0d got=%h want=%h", i, obs_main, exp_main());
      end
    end
  endtask

  task automatic test_clr_bad();
    int v;
    v = (up + 3) % 8;
    tick(v, 1'b1);
    up = v + 1;
    total++;
    if ({err_pulse, err_cnt, fault, locked} !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL clr_bad got ep=%b err=%0d f=%b l=%b want 1/0/0/0", err_pulse, err_cnt, fault, locked);
    end
    for (int i = 0; i < 3; i++) begin
      clean(1'b0);
      total++;
      if (fault !== 1'b0 || obs_main !== exp_main()) begin
        bad++; $display("FAIL clr_bad_after cyc=%0d got=%h want=%h", i, obs_main, exp_main());
      end
    end
  endtask

  task automatic test_random();
    int v;
    bit c;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 10) begin
        v = (up + $urandom_range(1, 7)) % 8;
        tick(v, c);
        up = v + 1;
      end else begin
        clean(c);
      end
      total++;
      if (obs_main !== exp_main()) begin bad++; $display("FAIL random_main cyc=%0d got=%h want=%h", i, obs_main, exp_main()); end
      total++;
      if (obs_small !== exp_small()) begin bad++; $display("FAIL random_small cyc=%0d got=%h want=%h", i, obs_small, exp_small()); end
      total++;
      if (locked && fault) begin bad++; $display("FAIL exclusive cyc=%0d got l=%b f=%b want not both", i, locked, fault); end
    end
  endtask

  initial begin
    test_reset();
    test_lock_wrap();
    test_upset();
    test_glitch();
    test_saturation();
    test_rollover();
    test_async_reset();
    test_clr_bad();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
